// File: rtl/parking_occupancy_ctrl.sv
// Parking occupancy controller: per-slot sensor debounce, occupancy counting,
// and an entry gate that admits cars only while a free slot can be guaranteed.
module parking_occupancy_ctrl #(
    parameter int SLOTS        = 8,
    parameter int DEB_CYCLES   = 4,
    parameter int GATE_TIMEOUT = 16,
    localparam int CNT_W       = $clog2(SLOTS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SLOTS-1:0] slot_sensor,
    input  logic             entry_req,
    input  logic             car_pass,
    output logic [SLOTS-1:0] slot_occ,
    output logic [CNT_W-1:0] occ_count,
    output logic [CNT_W-1:0] free_count,
    output logic [CNT_W-1:0] pending,
    output logic             full,
    output logic             empty,
    output logic             gate_open,
    output logic             deny,
    output logic             timeout
);

    localparam int DEB_W = $clog2(DEB_CYCLES + 1);
    localparam int TMR_W = $clog2(GATE_TIMEOUT);

    localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(GATE_TIMEOUT - 1);
    localparam logic [CNT_W:0]   SLOTS_EXT = (CNT_W + 1)'(SLOTS);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_OPEN = 1'b1;

    logic [SLOTS-1:0] sync1, sync2;
    logic [DEB_W-1:0] deb_cnt [SLOTS];
    logic [CNT_W-1:0] pop_count;
    logic [CNT_W-1:0] occ_prev;
    logic [CNT_W-1:0] occ_rise;
    logic [CNT_W-1:0] pend_dec;
    logic [CNT_W:0]   pend_sum;
    logic [CNT_W-1:0] pend_next;
    logic             state;
    logic [TMR_W-1:0] timer;
    logic             admit_ok;
    logic             pass_ok;

    // Two-flop synchroniser followed by the per-slot debounce counters.
    // NOTE: the counter array is a bank of flops, not a RAM, so it resets like any other register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= '0;
            sync2    <= '0;
            slot_occ <= '0;
            for (int i = 0; i < SLOTS; i++) deb_cnt[i] <= '0;
        end else begin
            sync1 <= slot_sensor;
            sync2 <= sync1;
            for (int i = 0; i < SLOTS; i++) begin
                if (sync2[i] == slot_occ[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    slot_occ[i] <= sync2[i];
                    deb_cnt[i]  <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    // NOTE: combinational accumulation uses blocking assignments and starts from a default, so no latch is inferred.
    always_comb begin
        pop_count = '0;
        for (int i = 0; i < SLOTS; i++) pop_count = pop_count + CNT_W'(slot_occ[i]);
    end

    assign free_count = CNT_W'(SLOTS) - occ_count;
    assign full       = (occ_count == CNT_W'(SLOTS));
    assign empty      = (occ_count == '0);
    assign admit_ok   = ({1'b0, occ_count} + {1'b0, pending}) < SLOTS_EXT;
    assign pass_ok    = (state == ST_OPEN) && car_pass;
    assign gate_open  = (state == ST_OPEN);

    // Newly parked cars retire admitted-but-unparked cars; departures leave pending alone.
    always_comb begin
        occ_rise  = (occ_count > occ_prev) ? (occ_count - occ_prev) : '0;
        pend_dec  = (occ_rise > pending) ? pending : occ_rise;
        pend_sum  = {1'b0, pending} - {1'b0, pend_dec} + (CNT_W + 1)'(pass_ok);
        pend_next = (pend_sum > SLOTS_EXT) ? CNT_W'(SLOTS) : pend_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_count <= '0;
            occ_prev  <= '0;
            pending   <= '0;
        end else begin
            occ_count <= pop_count;
            occ_prev  <= occ_count;
            pending   <= pend_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            timer   <= '0;
            deny    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            deny    <= 1'b0;
            timeout <= 1'b0;
            if (state == ST_IDLE) begin
                if (entry_req && admit_ok) begin
                    state <= ST_OPEN;
                    timer <= '0;
                end else if (entry_req) begin
                    deny <= 1'b1;
                end
            end else begin
                if (car_pass) begin
                    state <= ST_IDLE;
                end else if (timer == TMR_LAST) begin
                    state   <= ST_IDLE;
                    timeout <= 1'b1;
                end else begin
                    timer <= timer + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_parking_occupancy_ctrl.sv
// Directed bench for parking_occupancy_ctrl: expectations are queued as stimulus
// is applied and popped against DUT outputs sampled 1 ns after each clock edge.
module tb_parking_occupancy_ctrl;

    localparam int SLOTS = 8;
    localparam int CNT_W = $clog2(SLOTS + 1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic [SLOTS-1:0] slot_sensor;
    logic             entry_req;
    logic             car_pass;
    logic [SLOTS-1:0] slot_occ;
    logic [CNT_W-1:0] occ_count;
    logic [CNT_W-1:0] free_count;
    logic [CNT_W-1:0] pending;
    logic             full;
    logic             empty;
    logic             gate_open;
    logic             deny;
    logic             timeout;

    parking_occupancy_ctrl #(
        .SLOTS(SLOTS),
        .DEB_CYCLES(4),
        .GATE_TIMEOUT(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .slot_sensor(slot_sensor),
        .entry_req(entry_req),
        .car_pass(car_pass),
        .slot_occ(slot_occ),
        .occ_count(occ_count),
        .free_count(free_count),
        .pending(pending),
        .full(full),
        .empty(empty),
        .gate_open(gate_open),
        .deny(deny),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    task automatic push_exp(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        exp_t e;
        tests_run++;
        if (sb_q.size() == 0) begin
            tests_failed++;
            $display("FAIL sb_underflow observed=%0h expected=<none>", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.val) else begin
                tests_failed++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string where);
        push_exp({where, "_slot_occ"}, 0);
        push_exp({where, "_occ_count"}, 0);
        push_exp({where, "_free_count"}, SLOTS);
        push_exp({where, "_pending"}, 0);
        push_exp({where, "_empty"}, 1);
        push_exp({where, "_full"}, 0);
        push_exp({where, "_gate_open"}, 0);
        push_exp({where, "_deny"}, 0);
        push_exp({where, "_timeout"}, 0);
        pop_check(slot_occ);
        pop_check(occ_count);
        pop_check(free_count);
        pop_check(pending);
        pop_check(empty);
        pop_check(full);
        pop_check(gate_open);
        pop_check(deny);
        pop_check(timeout);
    endtask

    task automatic do_reset(input string where);
        slot_sensor = '0;
        entry_req   = 1'b0;
        car_pass    = 1'b0;
        rst_n       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state(where);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        int open_cycles;
        int timeout_pulses;

        // Power-on reset.
        do_reset("por");

        // Admit one car into an empty lot; it then parks in slot 0.
        entry_req = 1'b1;
        push_exp("open_on_req", 1);
        tick(1);
        pop_check(gate_open);
        entry_req = 1'b0;
        push_exp("open_held", 1);
        tick(2);
        pop_check(gate_open);
        car_pass = 1'b1;
        push_exp("pass_closes", 0);
        push_exp("pass_pending", 1);
        tick(1);
        car_pass = 1'b0;
        pop_check(gate_open);
        pop_check(pending);
        car_pass = 1'b1;
        push_exp("idle_pass_ignored", 1);
        tick(1);
        car_pass = 1'b0;
        pop_check(pending);
        slot_sensor = 8'h01;
        push_exp("slot0_pre", 8'h00);
        tick(5);
        pop_check(slot_occ);
        push_exp("slot0_occ", 8'h01);
        push_exp("slot0_pending_hold", 1);
        tick(1);
        pop_check(slot_occ);
        pop_check(pending);
        push_exp("slot0_count", 1);
        push_exp("slot0_pending_lag", 1);
        tick(1);
        pop_check(occ_count);
        pop_check(pending);
        push_exp("slot0_pending_clear", 0);
        tick(1);
        pop_check(pending);

        // Steady 8'h05 from reset: slot_occ after 6 edges, counts after 7.
        do_reset("rst2");
        slot_sensor = 8'h05;
        push_exp("deb_edge5", 8'h00);
        tick(5);
        pop_check(slot_occ);
        push_exp("deb_edge6", 8'h05);
        push_exp("deb_edge6_count", 0);
        tick(1);
        pop_check(slot_occ);
        pop_check(occ_count);
        push_exp("cnt_edge7", 2);
        push_exp("free_edge7", 6);
        push_exp("empty_edge7", 0);
        push_exp("full_edge7", 0);
        tick(1);
        pop_check(occ_count);
        pop_check(free_count);
        pop_check(empty);
        pop_check(full);

        // Three-sample glitch on slot 3 must be filtered.
        slot_sensor = 8'h0D;
        tick(3);
        slot_sensor = 8'h05;
        push_exp("glitch_occ", 8'h05);
        push_exp("glitch_count", 2);
        tick(8);
        pop_check(slot_occ);
        pop_check(occ_count);

        // Seven occupied plus one admitted car: further requests are denied.
        slot_sensor = 8'h7F;
        push_exp("seven_occ", 8'h7F);
        push_exp("seven_count", 7);
        push_exp("seven_free", 1);
        tick(7);
        pop_check(slot_occ);
        pop_check(occ_count);
        pop_check(free_count);
        entry_req = 1'b1;
        push_exp("last_admit", 1);
        tick(1);
        pop_check(gate_open);
        entry_req = 1'b0;
        car_pass  = 1'b1;
        push_exp("last_pending", 1);
        tick(1);
        car_pass = 1'b0;
        pop_check(pending);
        entry_req = 1'b1;
        push_exp("deny_1", 1);
        push_exp("deny_gate", 0);
        tick(1);
        pop_check(deny);
        pop_check(gate_open);
        push_exp("deny_2", 1);
        tick(1);
        pop_check(deny);
        entry_req = 1'b0;
        push_exp("deny_drop", 0);
        push_exp("deny_gate_idle", 0);
        tick(1);
        pop_check(deny);
        pop_check(gate_open);
        slot_sensor = 8'hFF;
        push_exp("full_flag", 1);
        push_exp("full_free", 0);
        push_exp("full_count", 8);
        push_exp("full_pending_lag", 1);
        tick(7);
        pop_check(full);
        pop_check(free_count);
        pop_check(occ_count);
        pop_check(pending);
        push_exp("full_pending_clear", 0);
        tick(1);
        pop_check(pending);

        // Gate timeout with no car_pass.
        do_reset("rst3");
        entry_req = 1'b1;
        tick(1);
        entry_req      = 1'b0;
        open_cycles    = gate_open ? 1 : 0;
        timeout_pulses = 0;
        push_exp("to_open_cycles", 16);
        push_exp("to_pulses", 1);
        push_exp("to_pending", 0);
        push_exp("to_gate_final", 0);
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (gate_open) open_cycles++;
            if (timeout) timeout_pulses++;
        end
        pop_check(open_cycles);
        pop_check(timeout_pulses);
        pop_check(pending);
        pop_check(gate_open);

        // Asynchronous reset while the gate is open with two cars pending.
        do_reset("rst4");
        slot_sensor = 8'h03;
        push_exp("ar_count", 2);
        tick(7);
        pop_check(occ_count);
        for (int k = 0; k < 2; k++) begin
            entry_req = 1'b1;
            tick(1);
            entry_req = 1'b0;
            car_pass  = 1'b1;
            tick(1);
            car_pass = 1'b0;
        end
        entry_req = 1'b1;
        push_exp("ar_open", 1);
        push_exp("ar_pending", 2);
        tick(1);
        entry_req = 1'b0;
        pop_check(gate_open);
        pop_check(pending);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("async");
        #2;
        rst_n = 1'b1;

        tests_run++;
        assert (sb_q.size() == 0) else begin
            tests_failed++;
            $error("FAIL sb_leftover observed=%0d expected=0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/parking_occupancy_ctrl.md
PARKING_OCCUPANCY_CTRL -- requirements
Module: parking_occupancy_ctrl

Interface
REQ-001 Parameter SLOTS, default 8: number of parking-slot sensors (1..255).
REQ-002 Parameter DEB_CYCLES, default 4: consecutive synchronised samples needed to accept a sensor change (1..255).
REQ-003 Parameter GATE_TIMEOUT, default 16: cycles the entry gate stays open without a car_pass before closing (2..65535).
REQ-004 Derived CNT_W = clog2(SLOTS+1): width of all count outputs.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 slot_sensor  in  SLOTS  raw asynchronous sensors; bit i = 1 means a car is in slot i.
REQ-008 entry_req  in  1  level request from the entry-lane detector.
REQ-009 car_pass  in  1  one-cycle pulse: a car has driven through the open gate.
REQ-010 slot_occ  out  SLOTS  debounced occupancy per slot.
REQ-011 occ_count  out  CNT_W  registered population count of slot_occ.
REQ-012 free_count  out  CNT_W  SLOTS - occ_count.
REQ-013 pending  out  CNT_W  cars admitted but not yet seen parked.
REQ-014 full / empty  out  1 each  occ_count == SLOTS / occ_count == 0.
REQ-015 gate_open  out  1  high while the entry gate FSM is in OPEN.
REQ-016 deny  out  1  one-cycle pulse when an entry request is refused.
REQ-017 timeout  out  1  one-cycle pulse when the gate closes without a car_pass.

Function
REQ-018 Each slot_sensor bit SHALL pass a 2-flop synchroniser before debounce.
REQ-019 Per slot, a debounce counter SHALL clear whenever the synchronised bit equals slot_occ[i] and increment otherwise; on the edge where it would reach DEB_CYCLES, slot_occ[i] takes the new value and the counter clears.
REQ-020 Glitches shorter than DEB_CYCLES synchronised samples SHALL NOT change slot_occ.
REQ-021 A steady change on a sensor SHALL appear on slot_occ after 2+DEB_CYCLES edges; occ_count, free_count, full and empty SHALL follow one edge later.
REQ-022 occ_count SHALL be computed without overflow for SLOTS up to 255; free_count never underflows.
REQ-023 admit_ok = (occ_count + pending) < SLOTS, evaluated at CNT_W+1 bits.
REQ-024 Gate FSM states: IDLE, OPEN.
REQ-025 IDLE: entry_req && admit_ok -> OPEN and gate timer cleared; entry_req && !admit_ok -> stay IDLE and pulse deny for one cycle per cycle refused.
REQ-026 OPEN: car_pass -> IDLE and pending increments; otherwise, when the timer reaches GATE_TIMEOUT-1 -> IDLE and pulse timeout; otherwise the timer increments.
REQ-027 car_pass SHALL be ignored in IDLE.
REQ-028 When occ_count increases by d on an edge, pending SHALL decrease by min(pending, d) on the next edge. Decreases in occ_count SHALL NOT change pending.
REQ-029 Simultaneous pending increment (car_pass) and decrement SHALL both apply in the same edge (net change).
REQ-030 pending SHALL saturate at SLOTS and SHALL never wrap below 0.
REQ-031 gate_open SHALL be a registered Moore output: high exactly when the state is OPEN.

Reset
REQ-032 When rst_n goes low, all state SHALL clear immediately, including when the gate is open: synchronisers, debounce counters, slot_occ = 0, occ_count = 0, free_count = SLOTS, pending = 0, empty = 1, full = 0, FSM = IDLE, gate_open = deny = timeout = 0.
REQ-033 After rst_n rises, the first state update SHALL occur on the next rising edge.

Verification
REQ-034 SLOTS=8, DEB_CYCLES=4: hold slot_sensor=8'h05 steady after reset -> slot_occ=8'h05 after 6 edges; occ_count=2 and free_count=6 after 7 edges.
REQ-035 Pulse slot_sensor[3] high for 3 synchronised cycles, then low -> slot_occ[3] stays 0 and occ_count is unchanged.
REQ-036 Apply entry_req with occ_count=0 and pending=0 -> gate_open=1 on the next edge; car_pass -> gate_open=0 and pending=1. Slot 0 then debounces high -> occ_count=1, then pending=0 one edge later.
REQ-037 Apply slot_sensor=8'h7F and admit one car (pending=1), then raise entry_req -> deny pulses, gate_open stays 0. Make all 8 sensors occupied -> full=1 and free_count=0.
REQ-038 GATE_TIMEOUT=16: open the gate with no car_pass -> gate_open high for exactly 16 cycles, a single timeout pulse, and pending unchanged.
REQ-039 Assert rst_n low while in OPEN with pending=2 -> outputs take their reset values asynchronously, before the next clk edge.
